// File: rtl/handshake_const_arbiter.sv
// Round-robin arbiter over NUM_IN control-only requesters; the winner's constant
// and index are loaded into a one-entry valid/ready output register.
module handshake_const_arbiter #(
  parameter int unsigned                    DATA_WIDTH = 32,
  parameter int unsigned                    NUM_IN     = 4,
  parameter logic [NUM_IN*DATA_WIDTH-1:0]   CONSTS     = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_IN-1:0]         ctrl_valid,
  output logic [NUM_IN-1:0]         ctrl_ready,
  output logic [DATA_WIDTH-1:0]     outs,
  output logic [$clog2(NUM_IN)-1:0] outs_index,
  output logic                      outs_valid,
  input  logic                      outs_ready
);

  localparam int unsigned IDX_W = $clog2(NUM_IN);

  logic [DATA_WIDTH-1:0] r_outs;
  logic [IDX_W-1:0]      r_index;
  logic                  r_valid;
  logic [IDX_W-1:0]      r_ptr;

  logic                  w_can_accept;
  logic                  w_found;
  logic [IDX_W-1:0]      w_win;
  logic [IDX_W-1:0]      w_sel;
  int unsigned           w_idx_int;
  logic                  w_xfer;
  logic [IDX_W-1:0]      w_ptr_nxt;
  logic [DATA_WIDTH-1:0] w_const;

  assign w_can_accept = ~r_valid | outs_ready;

  // First asserted request at or after r_ptr, wrapping modulo NUM_IN.
  always_comb begin
    w_found   = 1'b0;
    w_win     = '0;
    w_sel     = '0;
    w_idx_int = 0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      w_idx_int = (32'(r_ptr) + k) % NUM_IN;
      w_sel     = IDX_W'(w_idx_int);
      if (!w_found && ctrl_valid[w_sel]) begin
        w_found = 1'b1;
        w_win   = w_sel;
      end
    end
  end

  // Gated by rst so ctrl_ready drops asynchronously with the reset.
  assign w_xfer     = rst & w_found & w_can_accept;
  assign ctrl_ready = w_xfer ? (NUM_IN'(1) << w_win) : '0;

  // Explicit wrap keeps the pointer in range for non-power-of-two NUM_IN.
  assign w_ptr_nxt = (w_win == IDX_W'(NUM_IN - 1)) ? '0 : w_win + IDX_W'(1);
  assign w_const   = CONSTS[32'(w_win)*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_outs  <= '0;
      r_index <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (w_xfer) begin
      r_outs  <= w_const;
      r_index <= w_win;
      r_valid <= 1'b1;
      r_ptr   <= w_ptr_nxt;
    end else if (outs_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign outs       = r_outs;
  assign outs_index = r_index;
  assign outs_valid = r_valid;

endmodule

// File: tb/tb_handshake_const_arbiter.sv
// Bench for handshake_const_arbiter: a 4-input and a 3-input instance driven with
// directed and random traffic, compared every cycle against a round-robin model.
module tb_handshake_const_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cv4;
  logic [2:0] cv3;
  logic       ordy4, ordy3;

  logic [3:0] crdy4;
  logic [7:0] outs4;
  logic [1:0] idx4;
  logic       ov4;
  logic [2:0] crdy3;
  logic [7:0] outs3;
  logic [1:0] idx3;
  logic       ov3;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  handshake_const_arbiter #(
    .DATA_WIDTH(8), .NUM_IN(4), .CONSTS({8'h44, 8'h33, 8'h22, 8'h11})
  ) dut4 (
    .clk(clk), .rst(rst), .ctrl_valid(cv4), .ctrl_ready(crdy4),
    .outs(outs4), .outs_index(idx4), .outs_valid(ov4), .outs_ready(ordy4)
  );

  handshake_const_arbiter #(
    .DATA_WIDTH(8), .NUM_IN(3), .CONSTS({8'hC3, 8'hB2, 8'hA1})
  ) dut3 (
    .clk(clk), .rst(rst), .ctrl_valid(cv3), .ctrl_ready(crdy3),
    .outs(outs3), .outs_index(idx3), .outs_valid(ov3), .outs_ready(ordy3)
  );

  typedef struct {
    bit v;
    int outs;
    int idx;
    int ptr;
  } mstate_t;

  mstate_t m4, m3;

  function automatic int const_of(int n, int i);
    int t4[4];
    int t3[3];
    t4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    t3 = '{8'hA1, 8'hB2, 8'hC3};
    return (n == 4) ? t4[i] : t3[i];
  endfunction

  // Round robin: first requester found scanning ptr, ptr+1, ... modulo n; -1 if none.
  function automatic int winner(int n, int ptr, logic [7:0] cv);
    int i;
    for (int k = 0; k < n; k++) begin
      i = (ptr + k) % n;
      if (cv[i]) return i;
    end
    return -1;
  endfunction

  function automatic int exp_ready(mstate_t s, int n, logic [7:0] cv, bit ordy, bit rstv);
    int w;
    w = winner(n, s.ptr, cv);
    if (!rstv || w < 0 || !(!s.v || ordy)) return 0;
    return 1 << w;
  endfunction

  function automatic mstate_t m_next(mstate_t s, int n, logic [7:0] cv, bit ordy, bit rstv);
    mstate_t r;
    int w;
    r = s;
    w = winner(n, s.ptr, cv);
    if (!rstv) begin
      r = '{v: 0, outs: 0, idx: 0, ptr: 0};
    end else if (w >= 0 && (!s.v || ordy)) begin
      r.v    = 1;
      r.outs = const_of(n, w);
      r.idx  = w;
      r.ptr  = (w + 1) % n;
    end else if (ordy) begin
      r.v = 0;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, compare shortly after, then advance the model.
  task automatic step(input bit r, input logic [3:0] c4, input bit o4,
                      input logic [2:0] c3, input bit o3, input string tag);
    @(negedge clk);
    rst = r; cv4 = c4; ordy4 = o4; cv3 = c3; ordy3 = o3;
    if (!r) begin
      m4 = '{v: 0, outs: 0, idx: 0, ptr: 0};
      m3 = '{v: 0, outs: 0, idx: 0, ptr: 0};
    end
    #1;
    chk({tag, ".rdy4"}, 32'(crdy4), exp_ready(m4, 4, 8'(c4), o4, r));
    chk({tag, ".ov4"},  32'(ov4),   32'(m4.v));
    chk({tag, ".outs4"}, 32'(outs4), m4.outs);
    chk({tag, ".idx4"}, 32'(idx4),  m4.idx);
    chk({tag, ".ptr4"}, 32'(dut4.r_ptr), m4.ptr);
    chk({tag, ".rdy3"}, 32'(crdy3), exp_ready(m3, 3, 8'(c3), o3, r));
    chk({tag, ".ov3"},  32'(ov3),   32'(m3.v));
    chk({tag, ".outs3"}, 32'(outs3), m3.outs);
    chk({tag, ".idx3"}, 32'(idx3),  m3.idx);
    chk({tag, ".ptr3"}, 32'(dut3.r_ptr), m3.ptr);
    m4 = m_next(m4, 4, 8'(c4), o4, r);
    m3 = m_next(m3, 3, 8'(c3), o3, r);
  endtask

  initial begin
    int seq_idx[8];
    rst = 1'b0; cv4 = '0; ordy4 = 1'b0; cv3 = '0; ordy3 = 1'b0;
    m4 = '{v: 0, outs: 0, idx: 0, ptr: 0};
    m3 = '{v: 0, outs: 0, idx: 0, ptr: 0};

    // Reset holds everything at zero even with requests present.
    step(0, 4'b0000, 0, 3'b000, 0, "rst_idle");
    step(0, 4'b1111, 1, 3'b111, 1, "rst_req");

    // Full-throughput rotation on both instances.
    seq_idx = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < 8; i++) begin
      step(1, 4'b1111, 1, 3'b111, 1, "rot");
      if (i > 0) chk("rot_seq_idx", 32'(idx4), seq_idx[i-1]);
    end
    step(1, 4'b0000, 1, 3'b000, 1, "drain");
    chk("drain_outs_hold", 32'(outs4), 8'h44);
    step(1, 4'b0000, 1, 3'b000, 1, "idle");

    // Single requester on channel 2.
    for (int i = 0; i < 4; i++) step(1, 4'b0100, 1, 3'b100, 1, "single");
    chk("single_outs", 32'(outs4), 8'h33);

    // Hold index 1, stall five cycles, then release with no bubble.
    step(1, 4'b0010, 1, 3'b010, 1, "load1");
    for (int i = 0; i < 5; i++) step(1, 4'b1111, 0, 3'b111, 0, "stall");
    chk("stall_outs", 32'(outs4), 8'h22);
    step(1, 4'b1111, 1, 3'b111, 1, "unstall");
    step(1, 4'b0000, 0, 3'b000, 0, "after_unstall");
    chk("unstall_idx", 32'(idx4), 2);

    for (int i = 0; i < 200; i++)
      step(1, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), "rand");

    // Reset mid-stream with a token held, then release with channels 1 and 3.
    step(1, 4'b1111, 0, 3'b111, 0, "prefill");
    step(1, 4'b1111, 0, 3'b111, 0, "held");
    step(0, 4'b1111, 1, 3'b111, 1, "midrst");
    step(1, 4'b1010, 1, 3'b010, 1, "release");
    step(1, 4'b1010, 1, 3'b010, 1, "post_release");
    chk("first_grant_idx", 32'(idx4), 1);

    for (int i = 0; i < 7; i++) step(1, 4'b1111, 1, 3'b111, 1, "tail");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
